i2c_target_regfile: RTL and testbench
=====================================

I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 Parameter I2C_ADDR_WIDTH, default 7, the target address width in bits.
REQ-002 Parameter I2C_DATA_WIDTH, default 8, the byte width in bits; the pointer byte also uses this width.
REQ-003 Parameter SLAVE_ADDRESS, default 7'h22, the address this target acknowledges.
REQ-004 Parameter REG_DEPTH, default 16, the number of internal registers; SHALL be a power of 2 and at most 2**I2C_DATA_WIDTH.
REQ-005 clk  input  1  the system clock; all logic is clocked on its rising edge.
REQ-006 rst  input  1  the reset; it is synchronous and active-high.
REQ-007 scl  input  1  the raw I2C clock; it is asynchronous to clk.
REQ-008 sda_i  input  1  the raw I2C data level; it is asynchronous to clk.
REQ-009 sda_oe  output  1  when 1, SDA is pulled low; the block never drives SDA high.
REQ-010 wr_stb  output  1  a one-clk pulse per register byte written from the bus.
REQ-011 wr_addr  output  log2(REG_DEPTH)  the register index for wr_stb.
REQ-012 wr_data  output  I2C_DATA_WIDTH  the byte for wr_stb.
REQ-013 busy  output  1  high from an addressed START until the STOP or the transaction abort.

Function
REQ-014 scl and sda_i SHALL each pass through a 2-flop synchronizer; all edges SHALL be detected on the synchronized copies.
REQ-015 START SHALL be a synchronized SDA falling edge while synchronized SCL is 1; STOP SHALL be a synchronized SDA rising edge while SCL is 1.
REQ-016 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-017 START in any state SHALL go to ADDR and clear the bit counter; a repeated START keeps the register pointer.
REQ-018 STOP in any state SHALL go to IDLE, release sda_oe and drop busy; a partial byte SHALL be discarded with no wr_stb.
REQ-019 Sampling SHALL happen on SCL rising edges, MSB first; SDA changes by this block SHALL occur within 2 clk after a synchronized SCL falling edge.
REQ-020 In ADDR, the address bits and R/W bit SHALL be sampled.
- On an address match, the FSM goes to ADDR_ACK and drives ACK for one SCL period.
- On a mismatch, including general call 0, the FSM goes to IGNORE with sda_oe held 0.
REQ-021 After a write address, the first byte SHALL load the register pointer as the byte's low log2(REG_DEPTH) bits, then be ACKed; following bytes SHALL go to WDATA.
REQ-022 Each full WDATA byte SHALL write regs[ptr], pulse wr_stb exactly one clk at the 8th SCL rise, ACK, and increment ptr modulo REG_DEPTH (REG_DEPTH-1 wraps to 0).
REQ-023 After a read address, RDATA SHALL shift out regs[ptr] MSB first (sda_oe = ~bit), then release SDA for the master ACK bit.
- On a master ACK, ptr increments modulo REG_DEPTH and the next byte follows.
- On a master NACK, the FSM goes to IGNORE.
REQ-024 In IGNORE, sda_oe SHALL be 0 and only START or STOP SHALL be acted on.
REQ-025 A START or STOP coincident with a data bit SHALL take priority over bit sampling.

Reset
REQ-026 While rst is high at a clk edge, the following SHALL be cleared:
- state to IDLE;
- sda_oe, wr_stb, busy, wr_addr and wr_data to 0;
- ptr and the bit counter to 0;
- every register to 0;
- the synchronizers to 1.
REQ-027 A reset mid-transaction SHALL release SDA in the next clk; the block SHALL then ignore the bus until the next START.

Configuration
REQ-028 With macro I2C_TARGET_GLITCH_FILTER_EN defined, the synchronized scl and sda SHALL each pass a 3-sample majority filter, adding 2 clk latency and rejecting pulses of 1 clk or less.
REQ-029 Without I2C_TARGET_GLITCH_FILTER_EN, no filter SHALL be present and the latency SHALL be that of REQ-014 only.

Verification
REQ-030 Bench with SCL period 40 clk; write 0x22/W, ptr 0x03, data 0xA5, 0x5A, then STOP -> 3 ACKs plus the address ACK; wr_stb pulses with (3,0xA5) and (4,0x5A); busy falls after STOP.
REQ-031 Write ptr 0x0F, data 0x11, 0x22 -> wr_stb pulses with (15,0x11) and (0,0x22) (wrap); pointer byte 0x13 selects register 3.
REQ-032 Write ptr 0x03, repeated START, 0x22/R, master ACK, then NACK -> bytes 0xA5 and 0x5A on SDA; sda_oe=0 after the NACK; STOP -> IDLE.
REQ-033 Address 0x23/W -> no ACK (SDA high on the 9th clock); the following bytes are ignored with no wr_stb.
REQ-034 STOP after 4 data bits -> no wr_stb and state IDLE; rst asserted during RDATA -> sda_oe=0 next clk and all registers read 0.
REQ-035 With I2C_TARGET_GLITCH_FILTER_EN, a 1-clk SDA low pulse while SCL=1 -> no START detected; without the macro, the same pulse -> START detected.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with an internal register file, written and read over the bus.
// Bus byte 1 after a write address selects the register pointer, following
// bytes are written with auto-increment. Reads stream regs[ptr] with
// auto-increment while the master ACKs.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter on the synchronized scl/sda (2 clk extra latency).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free or not addressed; waits for START
// ADDR      | shifting in address bits and R/W
// ADDR_ACK  | driving ACK for a matched address
// PTR       | shifting in the register pointer byte
// PTR_ACK   | driving ACK for the pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for a written byte
// RDATA     | shifting out regs[ptr], MSB first
// RDATA_ACK | SDA released, sampling master ACK/NACK
// IGNORE    | not addressed or read aborted; only START/STOP matter
module i2c_target_regfile #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = 7'h22,
    parameter int                        REG_DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scl,
    input  logic                         sda_i,
    output logic                         sda_oe,
    output logic                         wr_stb,
    output logic [$clog2(REG_DEPTH)-1:0] wr_addr,
    output logic [I2C_DATA_WIDTH-1:0]    wr_data,
    output logic                         busy
);
    localparam int AW        = I2C_ADDR_WIDTH;
    localparam int DW        = I2C_DATA_WIDTH;
    localparam int PW        = $clog2(REG_DEPTH);
    localparam int ADDR_BITS = AW + 1;
    localparam int SHW       = (ADDR_BITS > DW) ? ADDR_BITS : DW;
    localparam int CW        = $clog2(SHW + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_c, sda_c, scl_prev_q, sda_prev_q;

    // Two-flop synchronizers for the asynchronous bus lines; idle level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_h_q, sda_h_q;
    logic       scl_f_q, sda_f_q;

    // Majority of the newest three synchronized samples, registered; a pulse
    // of one clk never wins the vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h_q <= 2'b11;
            sda_h_q <= 2'b11;
            scl_f_q <= 1'b1;
            sda_f_q <= 1'b1;
        end else begin
            scl_h_q <= {scl_h_q[0], scl_s2_q};
            sda_h_q <= {sda_h_q[0], sda_s2_q};
            scl_f_q <= (scl_s2_q & scl_h_q[0]) | (scl_s2_q & scl_h_q[1]) | (scl_h_q[0] & scl_h_q[1]);
            sda_f_q <= (sda_s2_q & sda_h_q[0]) | (sda_s2_q & sda_h_q[1]) | (sda_h_q[0] & sda_h_q[1]);
        end
    end

    assign scl_c = scl_f_q;
    assign sda_c = sda_f_q;
`else
    assign scl_c = scl_s2_q;
    assign sda_c = sda_s2_q;
`endif

    // Previous clean levels for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c &  scl_prev_q;
    assign start_det = ~sda_c &  sda_prev_q & scl_c;
    assign stop_det  =  sda_c & ~sda_prev_q & scl_c;

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SHW-1:0]      shift_q, shift_d, shift_in;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                rw_q, rw_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_stb_q, wr_stb_d;
    logic [PW-1:0]       wr_addr_q, wr_addr_d;
    logic [DW-1:0]       wr_data_q, wr_data_d;
    logic                reg_we;
    logic [DW-1:0]       regs_q [REG_DEPTH];

    assign shift_in = {shift_q[SHW-2:0], sda_c};

    // Next-state logic: START/STOP first, then per-state bit handling.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q != CW'(ADDR_BITS)) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else if (scl_fall && bit_cnt_q == CW'(ADDR_BITS)) begin
                        bit_cnt_d = '0;
                        if (shift_q[AW:1] == SLAVE_ADDRESS) begin
                            state_d  = ADDR_ACK;
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = RDATA;
                            shift_d  = SHW'(regs_q[ptr_q]);
                            sda_oe_d = ~regs_q[ptr_q][DW-1];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR, WDATA: begin
                    if (scl_rise && bit_cnt_q != CW'(DW)) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(DW - 1)) begin
                            if (state_q == PTR) begin
                                ptr_d = shift_in[PW-1:0];
                            end else begin
                                reg_we    = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = shift_in[DW-1:0];
                                ptr_d     = ptr_q + PW'(1);
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == CW'(DW)) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        state_d   = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = WDATA;
                        sda_oe_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && bit_cnt_q != CW'(DW)) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else if (scl_fall && bit_cnt_q == CW'(DW)) begin
                        state_d   = RDATA_ACK;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end else if (scl_fall && bit_cnt_q != '0) begin
                        shift_d  = shift_q << 1;
                        sda_oe_d = ~shift_q[DW-2];
                    end
                end
                RDATA_ACK: begin
                    // Entered on a fall, so the ACK rise always precedes the next fall.
                    if (scl_rise) begin
                        if (!sda_c) begin
                            ptr_d = ptr_q + PW'(1);
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        state_d   = RDATA;
                        bit_cnt_d = '0;
                        shift_d   = SHW'(regs_q[ptr_q]);
                        sda_oe_d  = ~regs_q[ptr_q][DW-1];
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file, written in the same clk the strobe is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[ptr_q] <= shift_in[DW-1:0];
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged master, SCL period 40 clk.
module tb_i2c_target_regfile;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       glitch = 1'b0;
    logic       sda_line;
    logic       sda_oe, wr_stb, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] stb_a[$];
    logic [7:0] stb_d[$];

    assign sda_line = sda_m & ~sda_oe & ~glitch;

    i2c_target_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda_i   (sda_line),
        .sda_oe  (sda_oe),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Every clk with wr_stb high records one write, so a stretched pulse shows as extra entries.
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_a.push_back(wr_addr);
            stb_d.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_clk(10);
        scl = 1'b0;   wait_clk(10);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl = 1'b0;   wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        sda_m = 1'b1; wait_clk(20);
    endtask

    task automatic send_bit(input logic b, input logic do_glitch);
        sda_m = b; wait_clk(10);
        scl = 1'b1; wait_clk(10);
        if (do_glitch) begin
            glitch = 1'b1; wait_clk(1);
            glitch = 1'b0; wait_clk(9);
        end else begin
            wait_clk(10);
        end
        scl = 1'b0; wait_clk(10);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        b = sda_line; wait_clk(10);
        scl = 1'b0;   wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] v, input int glitch_at, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i], glitch_at == i);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(~master_ack, 1'b0);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] exp_a0;
        logic [3:0] exp_a1;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         exp_gl_stb;
        logic       exp_gl_ack;

        vecs[0] = '{ptr: 8'h13, d0: 8'hC3, d1: 8'h3C, exp_a0: 4'd3,  exp_a1: 4'd4, exp_d0: 8'hC3, exp_d1: 8'h3C};
        vecs[1] = '{ptr: 8'h0F, d0: 8'h11, d1: 8'h22, exp_a0: 4'd15, exp_a1: 4'd0, exp_d0: 8'h11, exp_d1: 8'h22};
        vecs[2] = '{ptr: 8'h03, d0: 8'hA5, d1: 8'h5A, exp_a0: 4'd3,  exp_a1: 4'd4, exp_d0: 8'hA5, exp_d1: 8'h5A};

        // Reset values
        wait_clk(5);
        check("rst_sda_oe",  32'(sda_oe),  32'd0);
        check("rst_wr_stb",  32'(wr_stb),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Table-driven writes: address, pointer, two data bytes, STOP
        for (int v = 0; v < 3; v++) begin
            stb_a.delete(); stb_d.delete();
            i2c_start();
            write_byte(8'h44, -1, ack);        check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'd1);
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
            write_byte(vecs[v].ptr, -1, ack);  check($sformatf("v%0d_ptr_ack", v), 32'(ack), 32'd1);
            write_byte(vecs[v].d0, -1, ack);   check($sformatf("v%0d_d0_ack", v), 32'(ack), 32'd1);
            write_byte(vecs[v].d1, -1, ack);   check($sformatf("v%0d_d1_ack", v), 32'(ack), 32'd1);
            i2c_stop();
            check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_stb_count", v), 32'(stb_a.size()), 32'd2);
            if (stb_a.size() >= 2) begin
                check($sformatf("v%0d_stb0_addr", v), 32'(stb_a[0]), 32'(vecs[v].exp_a0));
                check($sformatf("v%0d_stb0_data", v), 32'(stb_d[0]), 32'(vecs[v].exp_d0));
                check($sformatf("v%0d_stb1_addr", v), 32'(stb_a[1]), 32'(vecs[v].exp_a1));
                check($sformatf("v%0d_stb1_data", v), 32'(stb_d[1]), 32'(vecs[v].exp_d1));
            end
            wait_clk(20);
        end

        // Read: pointer 3, repeated START, read with ACK then NACK
        stb_a.delete(); stb_d.delete();
        i2c_start();
        write_byte(8'h44, -1, ack);  check("rd_waddr_ack", 32'(ack), 32'd1);
        write_byte(8'h03, -1, ack);  check("rd_ptr_ack", 32'(ack), 32'd1);
        i2c_rstart();
        write_byte(8'h45, -1, ack);  check("rd_raddr_ack", 32'(ack), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        read_byte(1'b1, rb);         check("rd_byte0", 32'(rb), 32'hA5);
        read_byte(1'b0, rb);         check("rd_byte1", 32'(rb), 32'h5A);
        check("rd_sda_oe_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();
        check("rd_busy_after_stop", 32'(busy), 32'd0);
        check("rd_no_stb", 32'(stb_a.size()), 32'd0);
        wait_clk(20);

        // Wrong address: no ACK, following bytes ignored
        stb_a.delete(); stb_d.delete();
        i2c_start();
        write_byte(8'h46, -1, ack);  check("na_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h00, -1, ack);  check("na_b1_ack", 32'(ack), 32'd0);
        write_byte(8'h77, -1, ack);  check("na_b2_ack", 32'(ack), 32'd0);
        check("na_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("na_no_stb", 32'(stb_a.size()), 32'd0);
        wait_clk(20);

        // STOP after 4 data bits: partial byte discarded
        stb_a.delete(); stb_d.delete();
        i2c_start();
        write_byte(8'h44, -1, ack);  check("pb_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h05, -1, ack);  check("pb_ptr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        i2c_stop();
        check("pb_no_stb", 32'(stb_a.size()), 32'd0);
        check("pb_busy", 32'(busy), 32'd0);
        check("pb_sda_oe", 32'(sda_oe), 32'd0);
        wait_clk(20);

        // 1-clk SDA low glitch while SCL high inside a data bit
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        exp_gl_stb = 2;
        exp_gl_ack = 1'b1;
`else
        exp_gl_stb = 0;
        exp_gl_ack = 1'b0;
`endif
        stb_a.delete(); stb_d.delete();
        i2c_start();
        write_byte(8'h44, -1, ack);  check("gl_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h06, -1, ack);  check("gl_ptr_ack", 32'(ack), 32'd1);
        write_byte(8'hFF, 3, ack);   check("gl_d0_ack", 32'(ack), 32'(exp_gl_ack));
        write_byte(8'h81, -1, ack);  check("gl_d1_ack", 32'(ack), 32'(exp_gl_ack));
        i2c_stop();
        check("gl_stb_count", 32'(stb_a.size()), 32'(exp_gl_stb));
        if (stb_a.size() == 2) begin
            check("gl_stb0", {20'd0, stb_a[0], stb_d[0]}, {20'd0, 4'd6, 8'hFF});
            check("gl_stb1", {20'd0, stb_a[1], stb_d[1]}, {20'd0, 4'd7, 8'h81});
        end
        wait_clk(20);

        // Reset during RDATA: SDA released next clk, registers cleared
        stb_a.delete(); stb_d.delete();
        i2c_start();
        write_byte(8'h44, -1, ack);  check("rr_waddr_ack", 32'(ack), 32'd1);
        write_byte(8'h03, -1, ack);  check("rr_ptr_ack", 32'(ack), 32'd1);
        i2c_rstart();
        write_byte(8'h45, -1, ack);  check("rr_raddr_ack", 32'(ack), 32'd1);
        recv_bit(ack);               check("rr_bit7", 32'(ack), 32'd1);
        check("rr_sda_oe_bit6", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check("rr_sda_oe_after_rst", 32'(sda_oe), 32'd0);
        check("rr_busy_after_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clk(5);
        i2c_stop();
        wait_clk(20);
        i2c_start();
        write_byte(8'h44, -1, ack);  check("rr2_waddr_ack", 32'(ack), 32'd1);
        write_byte(8'h03, -1, ack);  check("rr2_ptr_ack", 32'(ack), 32'd1);
        i2c_rstart();
        write_byte(8'h45, -1, ack);  check("rr2_raddr_ack", 32'(ack), 32'd1);
        read_byte(1'b1, rb);         check("rr2_reg3", 32'(rb), 32'h00);
        read_byte(1'b0, rb);         check("rr2_reg4", 32'(rb), 32'h00);
        i2c_stop();
        check("rr2_no_stb", 32'(stb_a.size()), 32'd0);
        wait_clk(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
